// File: rtl/deser8_demux_if.sv
// deser8_demux_if: serial-in / word-out bundle
// for the 8:1 receive demultiplexer.
interface deser8_demux_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] slot;
  logic       busy;
  logic       err;

  modport master (
    output din, din_valid, sync,
    input  q, q_valid, slot, busy, err
  );

  modport slave (
    input  din, din_valid, sync,
    output q, q_valid, slot, busy, err
  );
endinterface

// File: rtl/deser8_demux.sv
// deser8_demux: 1-bit serial to 8-bit word demux
// with sync-based framing, resync and stall timeout.
module deser8_demux #(
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic             clk,
  input logic             resetn,
  deser8_demux_if.slave   bus
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t        state;
  logic [7:0]    fbuf;
  logic [7:0]    q;
  logic          q_valid;
  logic          err;
  logic [2:0]    slot;
  logic [CW-1:0] stall;

  function automatic logic [7:0] put(
    input logic [7:0] b,
    input logic [2:0] k,
    input logic       d
  );
    logic [7:0] r;
    r = b;
    r[MSB_FIRST ? 3'd7 - k : k] = d;
    return r;
  endfunction

  // Frame FSM: slot stepping, word assembly, abort handling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      fbuf    <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
      slot    <= '0;
      stall   <= '0;
    end else begin
      q_valid <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          stall <= '0;
          if (bus.din_valid && bus.sync) begin
            fbuf  <= put(8'h00, 3'd0, bus.din);
            slot  <= 3'd1;
            state <= RECV;
          end
        end
        RECV: begin
          if (bus.din_valid) begin
            stall <= '0;
            if (bus.sync) begin
              err  <= 1'b1;
              fbuf <= put(8'h00, 3'd0, bus.din);
              slot <= 3'd1;
            end else if (slot == 3'd7) begin
              q       <= put(fbuf, 3'd7, bus.din);
              q_valid <= 1'b1;
              slot    <= 3'd0;
              state   <= IDLE;
            end else begin
              fbuf <= put(fbuf, slot, bus.din);
              slot <= slot + 3'd1;
            end
          end else if (TIMEOUT != 0) begin
            if (stall == TLAST) begin
              err   <= 1'b1;
              slot  <= 3'd0;
              stall <= '0;
              state <= IDLE;
            end else begin
              stall <= stall + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.q       = q;
  assign bus.q_valid = q_valid;
  assign bus.err     = err;
  assign bus.slot    = slot;
  assign bus.busy    = (state == RECV);

endmodule

// File: doc/deser8_demux.md
Name: deser8_demux

Overview:
- Receive-side counterpart of the 8:1 select-driven serializer.
- A serial stream is produced by stepping a 3-bit select 0..7 over an 8-bit word. This block steps its own 3-bit slot counter, demultiplexes each incoming bit into the matching buffer slot, and presents the reassembled 8-bit word with a one-cycle valid strobe.
- It sits at the far end of the serial link and feeds the parallel datapath.

Parameters:
- TIMEOUT, 16, consecutive stall cycles (din_valid low while mid-frame) before the partial frame is aborted; 0 disables the timeout.
- MSB_FIRST, 0, 0: first bit of a frame lands in q[0] (slot k -> q[k]); 1: first bit lands in q[7] (slot k -> q[7-k]).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on this edge when high.
- sync  input  1  frame start; marks the current valid bit as slot 0. Ignored when din_valid is low.
- q  output  8  last complete frame; held until the next frame completes.
- q_valid  output  1  one-cycle pulse, high in the cycle after the 8th bit is accepted.
- slot  output  3  index of the next slot to be filled; 0 when idle.
- busy  output  1  high while in RECV.
- err  output  1  one-cycle pulse on frame abort (resync or timeout).

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; q=0, q_valid=0, slot=0, busy=0, err=0; internal buffer and stall counter cleared. Reset asserted mid-frame discards the partial frame immediately.
- States: IDLE, RECV.
- IDLE, din_valid && sync: din -> buffer slot 0, slot<=1, go RECV.
- IDLE, din_valid without sync: bit dropped, stay IDLE, no err.
- RECV, din_valid && !sync: din -> buffer[slot], slot<=slot+1, stall counter cleared.
- RECV, accepting slot 7:
  - q <= buffer with the slot-7 bit merged in; q_valid=1 for exactly one cycle after that edge.
  - slot wraps to 0; go IDLE.
- RECV, din_valid && sync (resync):
  - err pulses for one cycle; partial frame discarded; q unchanged.
  - din -> slot 0, slot<=1, stay RECV.
  - Applies at any slot 1..7. A sync coinciding with slot 7 is a resync, not a completion.
- RECV, din_valid low: hold all state; stall counter increments.
  - TIMEOUT>0 and counter reaches TIMEOUT: err pulses, go IDLE, slot=0, q unchanged.
- Back-to-back frames: a sync bit in the cycle immediately after completion is accepted with zero gap. Sustained throughput is 1 frame per 8 valid cycles.
- Latency: 8th valid bit sampled at edge N; q and q_valid visible after edge N, i.e. in cycle N+1.
- Buffer slots not yet written in the current frame never reach q.
- q_valid and err are never high in the same cycle.

Test Plan:
- Reset, then send sync+8 bits 1,0,1,1,0,0,1,0 (slot 0 first) on consecutive cycles, MSB_FIRST=0 -> q=8'h4D, q_valid high exactly 1 cycle, busy low afterwards.
- Same stream with MSB_FIRST=1 -> q=8'hB2.
- Two frames back-to-back, 8'hA5 then 8'h3C, with no idle cycle -> q_valid pulses exactly 8 cycles apart, q=8'hA5 then 8'h3C, err never high.
- Start frame 8'hFF, assert sync again on slot 4 followed by 8'h00 -> err pulses once at the resync edge, q goes straight from its prior value to 8'h00.
- TIMEOUT=16: send 3 bits, then hold din_valid low 16 cycles -> err pulse on the 16th stall cycle, slot=0, busy=0, q unchanged. Repeat with a 15-cycle stall -> frame completes normally.
- Assert resetn low mid-frame at slot 5 -> all outputs 0 immediately (asynchronous). Bits sent without sync after release are ignored until the next sync.
